alu: RTL and testbench

//   8-bit registered ALU for the mini-CPU datapath. Each cycle it performs one of eight operations on

---
 rtl/alu.sv | 74 +++++++
 tb/tb_alu.sv | 72 +++++++
 2 files changed

// File: rtl/alu.sv
// alu: 8-bit registered ALU with carry/overflow/zero/negative flags; ALU_SAT_EN enables signed saturation
//   a, b    in  8  operands (b[2:0] is the SLL shift amount)
//   clk     in  1  rising-edge clock
//   areset  in  1  asynchronous active-low reset
//   op      in  3  0 ADDU, 1 SUBU, 2 ADDS, 3 SUBS, 4 AND, 5 OR, 6 XOR, 7 SLL
//   result  out 8  registered result
//   cf      out 1  registered carry/borrow
//   ovf     out 1  registered signed overflow
//   z       out 1  registered zero
//   neg     out 1  registered negative
module alu (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       clk,
    input  logic       areset,
    input  logic [2:0] op,
    output logic [7:0] result,
    output logic       cf,
    output logic       ovf,
    output logic       z,
    output logic       neg
);
`ifdef ALU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    logic [8:0] sum, dif;
    logic       add_ovf, sub_ovf;
    logic [7:0] sat, res_d, res_q;
    logic       cf_d, cf_q, ovf_d, ovf_q, z_q, neg_q;
    assign sum     = {1'b0, a} + {1'b0, b};
    // bit 8 of the 9-bit difference is the unsigned borrow
    assign dif     = {1'b0, a} - {1'b0, b};
    assign add_ovf = (a[7] == b[7]) && (sum[7] != a[7]);
    assign sub_ovf = (a[7] != b[7]) && (dif[7] != a[7]);
    // on any signed overflow the true result has the sign of a
    assign sat     = a[7] ? 8'h80 : 8'h7F;
    always_comb begin
        res_d = 8'h00;
        cf_d  = 1'b0;
        ovf_d = 1'b0;
        case (op)
            3'd0: begin res_d = sum[7:0]; cf_d = sum[8]; end
            3'd1: begin res_d = dif[7:0]; cf_d = dif[8]; end
            3'd2: begin res_d = (SAT_EN && add_ovf) ? sat : sum[7:0]; ovf_d = add_ovf; end
            3'd3: begin res_d = (SAT_EN && sub_ovf) ? sat : dif[7:0]; ovf_d = sub_ovf; end
            3'd4: res_d = a & b;
            3'd5: res_d = a | b;
            3'd6: res_d = a ^ b;
            3'd7: res_d = a << b[2:0];
        endcase
    end
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            res_q <= 8'h00;
            cf_q  <= 1'b0;
            ovf_q <= 1'b0;
            z_q   <= 1'b0;
            neg_q <= 1'b0;
        end else begin
            res_q <= res_d;
            cf_q  <= cf_d;
            ovf_q <= ovf_d;
            z_q   <= (res_d == 8'h00);
            neg_q <= res_d[7];
        end
    end
    assign result = res_q;
    assign cf     = cf_q;
    assign ovf    = ovf_q;
    assign z      = z_q;
    assign neg    = neg_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector self-checking bench for alu
module tb_alu;
    logic [7:0] a, b, result;
    logic [2:0] op;
    logic       clk, areset, cf, ovf, z, neg;
    int         checks, errors;

    alu dut (
        .a(a), .b(b), .clk(clk), .areset(areset), .op(op),
        .result(result), .cf(cf), .ovf(ovf), .z(z), .neg(neg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got result=%h cf=%b ovf=%b z=%b neg=%b, expected result=%h cf=%b ovf=%b z=%b neg=%b",
                     tag, got[11:4], got[3], got[2], got[1], got[0], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // exp packs {result, cf, ovf, z, neg}
    task automatic run(input string tag, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [11:0] exp);
        @(negedge clk);
        op = o; a = x; b = y;
        @(posedge clk);
        #1 chk(tag, {result, cf, ovf, z, neg}, exp);
    endtask

    initial begin
        checks = 0; errors = 0;
        areset = 1'b0; a = 8'h55; b = 8'hAA; op = 3'd5;
        #8 chk("reset_hold", {result, cf, ovf, z, neg}, 12'h000);
        #4 areset = 1'b1;
        run("addu_12_7",   3'd0, 8'd12,  8'd7,   {8'h13, 4'b0000});
        run("addu_ff_1",   3'd0, 8'hFF,  8'h01,  {8'h00, 4'b1010});
        run("subu_120_50", 3'd1, 8'd120, 8'd50,  {8'h46, 4'b0000});
        run("subu_50_120", 3'd1, 8'd50,  8'd120, {8'hBA, 4'b1001});
`ifdef ALU_SAT_EN
        run("adds_127_1",  3'd2, 8'h7F,  8'h01,  {8'h7F, 4'b0100});
`else
        run("adds_127_1",  3'd2, 8'h7F,  8'h01,  {8'h80, 4'b0101});
`endif
        run("adds_m11_m14", 3'd2, 8'hF5, 8'hF2,  {8'hE7, 4'b0001});
`ifdef ALU_SAT_EN
        run("subs_m100_100", 3'd3, 8'h9C, 8'h64, {8'h80, 4'b0101});
`else
        run("subs_m100_100", 3'd3, 8'h9C, 8'h64, {8'h38, 4'b0100});
`endif
        run("subs_m43_10", 3'd3, 8'hD5,  8'h0A,  {8'hCB, 4'b0001});
        run("and",         3'd4, 8'h9B,  8'h57,  {8'h13, 4'b0000});
        run("xor",         3'd6, 8'h9B,  8'h57,  {8'hCC, 4'b0001});
        run("or",          3'd5, 8'h9B,  8'h57,  {8'hDF, 4'b0001});
        #2 areset = 1'b0;
        #1 chk("async_reset", {result, cf, ovf, z, neg}, 12'h000);
        @(posedge clk);
        #1 chk("reset_over_edge", {result, cf, ovf, z, neg}, 12'h000);
        @(negedge clk);
        areset = 1'b1;
        run("sll_7",       3'd7, 8'hF0,  8'hFF,  {8'h00, 4'b0010});
        run("sll_hi_ign",  3'd7, 8'h0F,  8'h09,  {8'h1E, 4'b0000});
        run("addu_back",   3'd0, 8'hC8,  8'h64,  {8'h2C, 4'b1000});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
